// File: rtl/eth_pkg.sv
// Shared types and widths for the 10G Ethernet TX path.
package eth_pkg;
  localparam int ETH_DATA_W       = 64;
  localparam int ETH_KEEP_W       = 8;
  localparam int ETH_TX_ARB_CNT_W = 32;

  typedef enum logic {ARB_IDLE, ARB_PASS} arb_state_t;

  typedef struct packed {
    logic [ETH_DATA_W-1:0] data;
    logic [ETH_KEEP_W-1:0] keep;
    logic                  last;
    logic                  user;
  } axis_beat_t;
endpackage

// File: rtl/eth_tx_arb_rr_pick.sv
// Round-robin priority picker: first request strictly after 'last', with wrap.
// Latency: combinational.
// Backpressure: none, pure function of req and last.
module rr_pick #(
  parameter int NREQ  = 2,
  parameter int IDX_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] last,
  output logic [NREQ-1:0]  onehot,
  output logic [IDX_W-1:0] idx,
  output logic             any
);
  logic [IDX_W-1:0] cand;

  always_comb begin
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    cand   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IDX_W'((int'(last) + k) % NREQ);
      if (!any && req[cand]) begin
        any          = 1'b1;
        onehot[cand] = 1'b1;
        idx          = cand;
      end
    end
  end
endmodule

// File: rtl/eth_tx_arb.sv
// Packet-granular round-robin arbiter onto one 64-bit AXI-Stream TX path; ETH_TX_ARB_CNT_EN adds frame counters.
// Latency: 1 cycle accept-to-output, one idle bubble between frames.
// Backpressure: granted tready follows ~m_axis_tvalid | m_axis_tready combinationally.
module eth_tx_arb
  import eth_pkg::*;
#(
  parameter int NREQ = 2
) (
  input  logic                       clk156,
  input  logic                       reset,
  input  logic [NREQ-1:0]            s_axis_tvalid,
  output logic [NREQ-1:0]            s_axis_tready,
  input  logic [NREQ*ETH_DATA_W-1:0] s_axis_tdata,
  input  logic [NREQ*ETH_KEEP_W-1:0] s_axis_tkeep,
  input  logic [NREQ-1:0]            s_axis_tlast,
  input  logic [NREQ-1:0]            s_axis_tuser,
  output logic                       m_axis_tvalid,
  input  logic                       m_axis_tready,
  output logic [ETH_DATA_W-1:0]      m_axis_tdata,
  output logic [ETH_KEEP_W-1:0]      m_axis_tkeep,
  output logic                       m_axis_tlast,
  output logic                       m_axis_tuser,
  output logic [NREQ-1:0]            grant,
`ifdef ETH_TX_ARB_CNT_EN
  output logic [NREQ*ETH_TX_ARB_CNT_W-1:0] frame_cnt,
`endif
  output logic                       busy
);
  localparam int IDX_W = $clog2(NREQ);

  arb_state_t       state;
  logic [IDX_W-1:0] last_idx;
  logic [IDX_W-1:0] gidx;
  logic [NREQ-1:0]  pick_onehot;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_any;
  logic             out_rdy;
  logic             accept;
  axis_beat_t       in_beat;
  axis_beat_t       out_beat;

  rr_pick #(.NREQ(NREQ), .IDX_W(IDX_W)) u_pick (
    .req    (s_axis_tvalid),
    .last   (last_idx),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  always_comb begin
    in_beat      = '0;
    in_beat.data = s_axis_tdata[gidx*ETH_DATA_W +: ETH_DATA_W];
    in_beat.keep = s_axis_tkeep[gidx*ETH_KEEP_W +: ETH_KEEP_W];
    in_beat.last = s_axis_tlast[gidx];
    in_beat.user = s_axis_tuser[gidx];
  end

  // grant is zero outside PASS, so only the frame owner can ever see tready.
  assign out_rdy       = ~m_axis_tvalid | m_axis_tready;
  assign s_axis_tready = (state == ARB_PASS && out_rdy) ? grant : '0;
  assign accept        = (state == ARB_PASS) && s_axis_tvalid[gidx] && out_rdy;

  always_ff @(posedge clk156) begin
    if (reset) begin
      state         <= ARB_IDLE;
      grant         <= '0;
      busy          <= 1'b0;
      gidx          <= '0;
      last_idx      <= IDX_W'(NREQ - 1);
      m_axis_tvalid <= 1'b0;
      out_beat      <= '0;
    end else begin
      if (state == ARB_IDLE) begin
        if (pick_any) begin
          state <= ARB_PASS;
          grant <= pick_onehot;
          gidx  <= pick_idx;
          busy  <= 1'b1;
        end
      end else if (accept && in_beat.last) begin
        state    <= ARB_IDLE;
        grant    <= '0;
        busy     <= 1'b0;
        last_idx <= gidx;
      end

      if (accept) begin
        out_beat      <= in_beat;
        m_axis_tvalid <= 1'b1;
      end else if (m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end
    end
  end

  assign m_axis_tdata = out_beat.data;
  assign m_axis_tkeep = out_beat.keep;
  assign m_axis_tlast = out_beat.last;
  assign m_axis_tuser = out_beat.user;

`ifdef ETH_TX_ARB_CNT_EN
  logic [NREQ-1:0][ETH_TX_ARB_CNT_W-1:0] cnt;

  always_ff @(posedge clk156) begin
    if (reset) begin
      cnt <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (accept && in_beat.last && gidx == IDX_W'(i))
          cnt[i] <= cnt[i] + 1'b1;
      end
    end
  end

  assign frame_cnt = cnt;
`endif
endmodule

// File: tb/tb_eth_tx_arb.sv
// Scoreboard bench for eth_tx_arb with three requesters and directed frames.
module tb_eth_tx_arb;
  import eth_pkg::*;
  localparam int N = 3;

  logic                     clk156;
  logic                     reset;
  logic [N-1:0]             s_axis_tvalid;
  logic [N-1:0]             s_axis_tready;
  logic [N*ETH_DATA_W-1:0]  s_axis_tdata;
  logic [N*ETH_KEEP_W-1:0]  s_axis_tkeep;
  logic [N-1:0]             s_axis_tlast;
  logic [N-1:0]             s_axis_tuser;
  logic                     m_axis_tvalid;
  logic                     m_axis_tready;
  logic [ETH_DATA_W-1:0]    m_axis_tdata;
  logic [ETH_KEEP_W-1:0]    m_axis_tkeep;
  logic                     m_axis_tlast;
  logic                     m_axis_tuser;
  logic [N-1:0]             grant;
  logic                     busy;
`ifdef ETH_TX_ARB_CNT_EN
  logic [N*ETH_TX_ARB_CNT_W-1:0] frame_cnt;
`endif

  eth_tx_arb #(.NREQ(N)) dut (
    .clk156        (clk156),
    .reset         (reset),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tkeep  (s_axis_tkeep),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tuser  (s_axis_tuser),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tuser  (m_axis_tuser),
    .grant         (grant),
`ifdef ETH_TX_ARB_CNT_EN
    .frame_cnt     (frame_cnt),
`endif
    .busy          (busy)
  );

  axis_beat_t   src_q [N][$];
  axis_beat_t   exp_q [$];
  logic [N-1:0] exp_gnt_q [$];
  int           popped [N];
  logic [N-1:0] hold;
  int           mode;
  int           n_chk;
  int           n_pass;
  int           cyc;
  int           first_t;
  int           last_t;
  int           n_xfer;
  logic [N-1:0] prev_g;

  initial begin
    clk156 = 1'b0;
    forever #5 clk156 = ~clk156;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk156);
      cyc++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d/%0d", n_pass, n_chk);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic axis_beat_t mk(input int r, input int f, input int b, input bit lst, input bit usr);
    axis_beat_t x;
    x.data = {8'hA5, 8'(r), 16'(f), 32'(b)};
    x.keep = lst ? 8'h0F : 8'hFF;
    x.last = lst;
    x.user = usr & lst;
    return x;
  endfunction

  // Frames must be added in the order the arbiter is expected to serve them.
  task automatic add_frame(input int r, input int f, input int nb, input bit usr);
    logic [N-1:0] g;
    axis_beat_t   x;
    for (int b = 0; b < nb; b++) begin
      x = mk(r, f, b, (b == nb - 1), usr);
      src_q[r].push_back(x);
      exp_q.push_back(x);
    end
    g    = '0;
    g[r] = 1'b1;
    exp_gnt_q.push_back(g);
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if (src_q[i].size() > 0) begin
        s_axis_tvalid[i]                   = ~hold[i];
        s_axis_tdata[i*ETH_DATA_W +: ETH_DATA_W] = src_q[i][0].data;
        s_axis_tkeep[i*ETH_KEEP_W +: ETH_KEEP_W] = src_q[i][0].keep;
        s_axis_tlast[i]                    = src_q[i][0].last;
        s_axis_tuser[i]                    = src_q[i][0].user;
      end else begin
        s_axis_tvalid[i]                   = 1'b0;
        s_axis_tdata[i*ETH_DATA_W +: ETH_DATA_W] = '0;
        s_axis_tkeep[i*ETH_KEEP_W +: ETH_KEEP_W] = '0;
        s_axis_tlast[i]                    = 1'b0;
        s_axis_tuser[i]                    = 1'b0;
      end
    end
  endtask

  task automatic tick();
    logic [N-1:0] acc;
    axis_beat_t   dummy;
    @(negedge clk156);
    acc = reset ? '0 : (s_axis_tvalid & s_axis_tready);
    @(posedge clk156);
    #1;
    for (int i = 0; i < N; i++) begin
      if (acc[i] && src_q[i].size() > 0) begin
        dummy = src_q[i].pop_front();
        popped[i]++;
      end
    end
    m_axis_tready = (mode == 1) ? ~m_axis_tready : 1'b1;
    drive();
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    for (int i = 0; i < n; i++) begin
      tick();
      check("rst_tready", 64'(s_axis_tready), 64'd0);
      check("rst_mvalid", 64'(m_axis_tvalid), 64'd0);
      check("rst_grant",  64'(grant), 64'd0);
    end
    reset = 1'b0;
    for (int i = 0; i < N; i++) popped[i] = 0;
  endtask

  task automatic drain(input string name);
    int k = 0;
    while ((exp_q.size() != 0 || exp_gnt_q.size() != 0) && k < 300) begin
      tick();
      k++;
    end
    check(name, 64'(exp_q.size() + exp_gnt_q.size()), 64'd0);
  endtask

  // Monitor: pops expectations whenever the DUT presents an output handshake or a new grant.
  initial begin
    axis_beat_t   e;
    logic [N-1:0] eg;
    prev_g = '0;
    forever begin
      @(negedge clk156);
      if (m_axis_tvalid && m_axis_tready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", m_axis_tdata, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("beat_data", m_axis_tdata, e.data);
          check("beat_ctl", 64'({m_axis_tkeep, m_axis_tlast, m_axis_tuser}), 64'({e.keep, e.last, e.user}));
        end
        if (n_xfer == 0) first_t = cyc;
        last_t = cyc;
        n_xfer++;
      end
      if (m_axis_tvalid && !m_axis_tready)
        check("stall_tready", 64'(s_axis_tready), 64'd0);
      if (|s_axis_tvalid)
        check("tready_owner", 64'(s_axis_tready & ~grant), 64'd0);
      if (grant != '0 && prev_g == '0) begin
        if (exp_gnt_q.size() == 0) begin
          check("unexpected_grant", 64'(grant), 64'd0);
        end else begin
          eg = exp_gnt_q.pop_front();
          check("grant_seq", 64'(grant), 64'(eg));
        end
      end
      prev_g = grant;
    end
  end

  initial begin
    axis_beat_t x;
    int         k;
    n_chk = 0; n_pass = 0; n_xfer = 0; first_t = 0; last_t = 0;
    mode = 0; hold = '0; reset = 1'b1; m_axis_tready = 1'b1;
    for (int i = 0; i < N; i++) popped[i] = 0;
    drive();

    // Reset held with every requester valid; requester 0 wins first afterwards.
    add_frame(0, 0, 1, 1'b0);
    add_frame(1, 0, 1, 1'b0);
    add_frame(2, 0, 1, 1'b1);
    drive();
    do_reset(3);
    tick();
    check("gnt_after_rst", 64'(grant), 64'd1);
    check("busy_after_rst", 64'(busy), 64'd1);
    drain("t1_drain");

    // Two requesters, 4-beat frames back to back: 4 frames take 20 cycles.
    do_reset(1);
    add_frame(0, 1, 4, 1'b0);
    add_frame(1, 1, 4, 1'b0);
    add_frame(0, 2, 4, 1'b1);
    add_frame(1, 2, 4, 1'b0);
    drive();
    n_xfer = 0;
    drain("t2_drain");
    check("t2_beats", 64'(n_xfer), 64'd16);
    check("t2_span", 64'(last_t - first_t), 64'd18);
`ifdef ETH_TX_ARB_CNT_EN
    check("t2_cnt0", 64'(frame_cnt[0 +: 32]), 64'd2);
    check("t2_cnt1", 64'(frame_cnt[32 +: 32]), 64'd2);
`endif

    // Output ready toggling every cycle mid-frame.
    do_reset(1);
    add_frame(0, 3, 8, 1'b0);
    drive();
    n_xfer = 0;
    mode = 1;
    drain("t3_drain");
    mode = 0;
    m_axis_tready = 1'b1;
    check("t3_beats", 64'(n_xfer), 64'd8);

    // Single-beat frames from all three: grants 0,1,2,0, two cycles each.
    do_reset(1);
    add_frame(0, 4, 1, 1'b0);
    add_frame(1, 4, 1, 1'b1);
    add_frame(2, 4, 1, 1'b0);
    add_frame(0, 5, 1, 1'b0);
    drive();
    n_xfer = 0;
    drain("t4_drain");
    check("t4_span", 64'(last_t - first_t), 64'd6);

    // Granted requester 1 stalls 5 cycles while requester 0 waits.
    do_reset(1);
    add_frame(1, 6, 4, 1'b0);
    drive();
    k = 0;
    while (popped[1] < 2 && k < 50) begin tick(); k++; end
    check("t5_wait", 64'(popped[1]), 64'd2);
    hold[1] = 1'b1;
    add_frame(0, 7, 4, 1'b0);
    drive();
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t5_hold_grant", 64'(grant), 64'd2);
    end
    check("t5_no_acc0", 64'(popped[0]), 64'd0);
    hold = '0;
    drive();
    drain("t5_drain");

    // Reset while beat 2 of an 8-beat frame is offered: only beats 0 and 1 leave.
    do_reset(1);
    for (int b = 0; b < 8; b++) begin
      x = mk(0, 8, b, (b == 7), 1'b0);
      src_q[0].push_back(x);
      if (b < 2) exp_q.push_back(x);
    end
    exp_gnt_q.push_back(3'b001);
    drive();
    k = 0;
    while (popped[0] < 2 && k < 50) begin tick(); k++; end
    check("t6_wait", 64'(popped[0]), 64'd2);
    reset = 1'b1;
    tick();
    check("t6_mvalid", 64'(m_axis_tvalid), 64'd0);
    check("t6_grant", 64'(grant), 64'd0);
`ifdef ETH_TX_ARB_CNT_EN
    check("t6_cnt0", 64'(frame_cnt[0 +: 32]), 64'd0);
`endif
    src_q[0].delete();
    reset = 1'b0;
    drive();
    tick();
    tick();
    check("t6_idle_busy", 64'(busy), 64'd0);
    drain("t6_drain");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
